wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: XLEN, default 64, datapath width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_valid_i  input  1  memory stage presents a retiring instruction.
REQ-005 mem_ready_o  output  1  wb_stage can accept; transfer occurs on an edge where mem_valid_i & mem_ready_o.
REQ-006 mem_pc_i  input  XLEN  PC of instruction.
REQ-007 mem_instr_i  input  32  raw instruction word.
REQ-008 mem_alu_i  input  XLEN  ALU result, or effective address for loads.
REQ-009 mem_rdata_i  input  XLEN  raw aligned doubleword read from data memory.
REQ-010 mem_is_load_i  input  1  instruction is a load.
REQ-011 mem_funct3_i  input  3  load width/sign code: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
REQ-012 mem_rdid_i  input  5  destination register index.
REQ-013 mem_wren_i  input  1  instruction writes rd.
REQ-014 wb_stall_i  input  1  hold commit this cycle (debug/difftest back-pressure).
REQ-015 wb_data_o  output  XLEN  register write data, to regfile write port.
REQ-016 wb_rdid_o  output  5  register write index.
REQ-017 wb_wren_o  output  1  register write enable, one-cycle pulse per committing write.
REQ-018 pc_wb_o  output  XLEN  PC of the committing instruction.
REQ-019 wb_valid_o  output  1  one-cycle pulse per committed instruction.
REQ-020 ebreak_o  output  1  pulses with wb_valid_o when committed instruction is 0x00100073.
REQ-021 retire_cnt_o  output  64  committed-instruction counter.

Function
REQ-022 2-entry FIFO holds {pc, instr, result, rdid, wren}; pointers 1 bit, wrap modulo 2; occupancy count 0..2.
REQ-023 mem_ready_o = (count != 2) & ~halted; derived from registered state only, never from a same-cycle pop.
REQ-024 Result captured at push: loads use extracted data (REQ-025/026); non-loads use mem_alu_i.
REQ-025 Load extraction: shift mem_rdata_i right by 8*mem_alu_i[2:0]; take low 8/16/32/64 bits per funct3; bits shifted in from above bit 63 read as zero; no misalignment trap.
REQ-026 Sign-extend for LB/LH/LW, zero-extend for LBU/LHU/LWU, LD unchanged; funct3 111 on a load yields 0.
REQ-027 Commit: on an edge with count != 0, ~wb_stall_i, ~halted, head entry pops and output registers load from it; wb_valid_o high in the following cycle only.
REQ-028 Latency: entry pushed at edge E into empty FIFO with no stall commits at edge E+1; wb_valid_o high during cycle after E+1.
REQ-029 Push and pop on same edge: both occur; count unchanged; throughput one instruction per cycle sustained.
REQ-030 wb_wren_o = committed wren & (rdid != 0); wb_data_o/wb_rdid_o/pc_wb_o hold last committed values when wb_valid_o is low.
REQ-031 retire_cnt_o increments by 1 on every commit; wraps 2^64-1 -> 0.
REQ-032 Committing ebreak sets sticky halted: no further commits or pushes; mem_ready_o low until reset; remaining entries held.
REQ-033 wb_stall_i stalls commit only; pushes continue until full.

Reset
REQ-034 While rst high at an edge: count=0, pointers=0, halted=0, retire_cnt_o=0, wb_valid_o=0, wb_wren_o=0, ebreak_o=0, wb_data_o=0, wb_rdid_o=0, pc_wb_o=0.
REQ-035 mem_ready_o = 0 during the reset cycle and 1 in the first cycle after rst falls.
REQ-036 rst mid-operation discards FIFO contents and any pending commit; no wb_valid_o pulse for discarded entries.

Verification
REQ-037 ADDI x5 result 0x2A, pc 0x80000000 pushed to empty FIFO -> two edges later wb_valid_o=1, wb_wren_o=1, wb_rdid_o=5, wb_data_o=0x2A, pc_wb_o=0x80000000, retire_cnt_o=1.
REQ-038 Loads, rdata 0x8877665544332211: LB addr offset 7 -> 0xFFFFFFFFFFFFFF88; LHU offset 2 -> 0x4433; LW offset 4 -> 0xFFFFFFFF88776655; LD offset 0 -> full word.
REQ-039 wb_stall_i held high, 3 back-to-back valids -> 2 accepted, mem_ready_o=0; release stall -> commits in order one per cycle, mem_ready_o reasserts.
REQ-040 Instruction with rdid=0, wren=1 -> wb_valid_o=1, wb_wren_o=0; retire_cnt_o still increments.
REQ-041 ebreak followed by ADDI -> ebreak_o and wb_valid_o pulse once; ADDI never commits; mem_ready_o stays 0 until rst.
REQ-042 rst asserted with FIFO full -> next cycle count=0, all outputs at reset values, mem_ready_o=1 after rst falls.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: 2-entry retire FIFO with load extraction, commit to regfile, retire counter and ebreak halt
module wb_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid_i,
  output logic            mem_ready_o,
  input  logic [XLEN-1:0] mem_pc_i,
  input  logic [31:0]     mem_instr_i,
  input  logic [XLEN-1:0] mem_alu_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_is_load_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [4:0]      mem_rdid_i,
  input  logic            mem_wren_i,
  input  logic            wb_stall_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rdid_o,
  output logic            wb_wren_o,
  output logic [XLEN-1:0] pc_wb_o,
  output logic            wb_valid_o,
  output logic            ebreak_o,
  output logic [63:0]     retire_cnt_o
);
  localparam logic [31:0] EBREAK = 32'h00100073;
  logic [XLEN-1:0] pc_q [2];
  logic [XLEN-1:0] res_q [2];
  logic [31:0]     ins_q [2];
  logic [4:0]      rd_q [2];
  logic            wr_q [2];
  logic [1:0]      count;
  logic            wptr, rptr, halted;
  logic [XLEN-1:0] sh, ld, res;
  logic            push, pop, head_eb;
  assign mem_ready_o = ~rst & (count != 2'd2) & ~halted;
  assign push = mem_valid_i & mem_ready_o;
  assign pop = (count != 2'd0) & ~wb_stall_i & ~halted;
  assign head_eb = ins_q[rptr] == EBREAK;
  assign sh = mem_rdata_i >> {mem_alu_i[2:0], 3'b000};
  always_comb begin
    ld = mem_funct3_i == 3'b000 ? {{(XLEN-8){sh[7]}}, sh[7:0]} :
         mem_funct3_i == 3'b001 ? {{(XLEN-16){sh[15]}}, sh[15:0]} :
         mem_funct3_i == 3'b010 ? {{(XLEN-32){sh[31]}}, sh[31:0]} :
         mem_funct3_i == 3'b011 ? sh :
         mem_funct3_i == 3'b100 ? {{(XLEN-8){1'b0}}, sh[7:0]} :
         mem_funct3_i == 3'b101 ? {{(XLEN-16){1'b0}}, sh[15:0]} :
         mem_funct3_i == 3'b110 ? {{(XLEN-32){1'b0}}, sh[31:0]} : '0;
    res = mem_is_load_i ? ld : mem_alu_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      halted       <= 1'b0;
      retire_cnt_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_wren_o    <= 1'b0;
      ebreak_o     <= 1'b0;
      wb_data_o    <= '0;
      wb_rdid_o    <= '0;
      pc_wb_o      <= '0;
    end else begin
      if (push) begin
        pc_q[wptr]  <= mem_pc_i;
        res_q[wptr] <= res;
        ins_q[wptr] <= mem_instr_i;
        rd_q[wptr]  <= mem_rdid_i;
        wr_q[wptr]  <= mem_wren_i;
        wptr        <= ~wptr;
      end
      if (pop) begin
        rptr      <= ~rptr;
        wb_data_o <= res_q[rptr];
        wb_rdid_o <= rd_q[rptr];
        pc_wb_o   <= pc_q[rptr];
      end
      wb_valid_o   <= pop;
      wb_wren_o    <= pop & wr_q[rptr] & (|rd_q[rptr]);
      ebreak_o     <= pop & head_eb;
      halted       <= halted | (pop & head_eb);
      retire_cnt_o <= retire_cnt_o + 64'(pop);
      count        <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed stimulus with a scoreboard queue checked by an independent commit monitor
module tb_wb_stage;
  logic        clk = 0, rst = 1;
  logic        mem_valid = 0, mem_ready_o;
  logic [63:0] mem_pc = 0, mem_alu = 0, mem_rdata = 0;
  logic [31:0] mem_instr = 0;
  logic        mem_is_load = 0, mem_wren = 0, wb_stall = 0;
  logic [2:0]  mem_funct3 = 0;
  logic [4:0]  mem_rdid = 0;
  logic [63:0] wb_data_o, pc_wb_o, retire_cnt_o;
  logic [4:0]  wb_rdid_o;
  logic        wb_wren_o, wb_valid_o, ebreak_o;
  typedef struct {logic [63:0] pc; logic [63:0] data; logic [4:0] rd; logic wr; logic eb;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int nvec = 0, nerr = 0;
  logic [63:0] exp_cnt = 0;
  localparam logic [63:0] RD = 64'h8877665544332211;
  wb_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_ready_o(mem_ready_o),
    .mem_pc_i(mem_pc), .mem_instr_i(mem_instr), .mem_alu_i(mem_alu), .mem_rdata_i(mem_rdata),
    .mem_is_load_i(mem_is_load), .mem_funct3_i(mem_funct3), .mem_rdid_i(mem_rdid),
    .mem_wren_i(mem_wren), .wb_stall_i(wb_stall), .wb_data_o(wb_data_o), .wb_rdid_o(wb_rdid_o),
    .wb_wren_o(wb_wren_o), .pc_wb_o(pc_wb_o), .wb_valid_o(wb_valid_o), .ebreak_o(ebreak_o),
    .retire_cnt_o(retire_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic send(input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] alu,
                      input logic [63:0] rdata, input logic ld, input logic [2:0] f3,
                      input logic [4:0] rd, input logic wr, input logic [63:0] exp_d, input logic exp_c);
    int t = 0;
    mem_valid = 1; mem_pc = pc; mem_instr = ins; mem_alu = alu; mem_rdata = rdata;
    mem_is_load = ld; mem_funct3 = f3; mem_rdid = rd; mem_wren = wr;
    while (!mem_ready_o && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!mem_ready_o) begin
      nvec++; nerr++;
      $display("FAIL handshake pc=%h: mem_ready_o got 0 want 1", pc);
      mem_valid = 0;
      return;
    end
    if (exp_c) sbq.push_back('{pc, exp_d, rd, wr && rd != 0, ins == 32'h00100073});
    @(posedge clk); #1;
    mem_valid = 0;
  endtask
  always @(negedge clk) begin
    if (rst) exp_cnt = 0;
    else if (wb_valid_o) begin
      nvec++;
      if (sbq.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_commit: got pc=%h want no commit", pc_wb_o);
      end else begin
        e = sbq.pop_front();
        exp_cnt++;
        if (pc_wb_o !== e.pc || wb_data_o !== e.data || wb_rdid_o !== e.rd || wb_wren_o !== e.wr ||
            ebreak_o !== e.eb || retire_cnt_o !== exp_cnt) begin
          nerr++;
          $display("FAIL commit: got pc=%h data=%h rd=%0d wr=%b eb=%b cnt=%0d want pc=%h data=%h rd=%0d wr=%b eb=%b cnt=%0d",
                   pc_wb_o, wb_data_o, wb_rdid_o, wb_wren_o, ebreak_o, retire_cnt_o,
                   e.pc, e.data, e.rd, e.wr, e.eb, exp_cnt);
        end
      end
    end else if (wb_wren_o || ebreak_o) begin
      nvec++; nerr++;
      $display("FAIL stray_pulse: got wren=%b ebreak=%b want 0 0", wb_wren_o, ebreak_o);
    end
  end
  logic [2:0]  lf3 [9] = '{3'b000, 3'b101, 3'b010, 3'b011, 3'b100, 3'b001, 3'b110, 3'b011, 3'b111};
  logic [2:0]  loff[9] = '{3'd7, 3'd2, 3'd4, 3'd0, 3'd7, 3'd6, 3'd4, 3'd4, 3'd0};
  logic [63:0] lexp[9] = '{64'hFFFFFFFFFFFFFF88, 64'h4433, 64'hFFFFFFFF88776655, RD, 64'h88,
                           64'hFFFFFFFFFFFF8877, 64'h88776655, 64'h0000000088776655, 64'h0};
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(wb_valid_o), 0);
    chk("rst_ready", 64'(mem_ready_o), 0);
    chk("rst_retire", retire_cnt_o, 0);
    chk("rst_data", wb_data_o, 0);
    rst = 0; #1;
    chk("ready_after_rst", 64'(mem_ready_o), 1);
    send(64'h80000000, 32'h02a00293, 64'h2a, 0, 0, 3'b000, 5'd5, 1, 64'h2a, 1);
    @(posedge clk); #1;
    chk("addi_valid", 64'(wb_valid_o), 1);
    chk("addi_wren", 64'(wb_wren_o), 1);
    chk("addi_rdid", 64'(wb_rdid_o), 5);
    chk("addi_data", wb_data_o, 64'h2a);
    chk("addi_pc", pc_wb_o, 64'h80000000);
    chk("addi_retire", retire_cnt_o, 1);
    for (int i = 0; i < 9; i++)
      send(64'h80000004 + 64'(4 * i), 32'h00003503, 64'h1000 + 64'(loff[i]), RD, 1, lf3[i], 5'd10, 1, lexp[i], 1);
    send(64'h80000040, 32'h00100013, 64'h1, 0, 0, 3'b000, 5'd0, 1, 64'h1, 1);
    repeat (5) @(posedge clk);
    #1;
    wb_stall = 1;
    send(64'h80000100, 32'h00100093, 64'h11, 0, 0, 3'b000, 5'd1, 1, 64'h11, 1);
    send(64'h80000104, 32'h00200113, 64'h22, 0, 0, 3'b000, 5'd2, 1, 64'h22, 1);
    chk("stall_full_ready", 64'(mem_ready_o), 0);
    chk("stall_no_commit", 64'(wb_valid_o), 0);
    wb_stall = 0;
    send(64'h80000108, 32'h00300193, 64'h33, 0, 0, 3'b000, 5'd3, 1, 64'h33, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_ready_back", 64'(mem_ready_o), 1);
    chk("stall_retire", retire_cnt_o, 14);
    wb_stall = 1;
    send(64'h80000200, 32'h00400213, 64'h44, 0, 0, 3'b000, 5'd4, 1, 64'h44, 0);
    send(64'h80000204, 32'h00500293, 64'h55, 0, 0, 3'b000, 5'd5, 1, 64'h55, 0);
    chk("full_ready", 64'(mem_ready_o), 0);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_data", wb_data_o, 0);
    chk("midrst_pc", pc_wb_o, 0);
    chk("midrst_rdid", 64'(wb_rdid_o), 0);
    chk("midrst_retire", retire_cnt_o, 0);
    chk("midrst_ready", 64'(mem_ready_o), 0);
    rst = 0; wb_stall = 0; #1;
    chk("midrst_ready_after", 64'(mem_ready_o), 1);
    repeat (4) @(posedge clk);
    #1;
    send(64'h80000300, 32'h00100073, 64'h0, 0, 0, 3'b000, 5'd0, 0, 64'h0, 1);
    send(64'h80000304, 32'h00600313, 64'h66, 0, 0, 3'b000, 5'd6, 1, 64'h66, 0);
    chk("ebreak_pulse", 64'(ebreak_o), 1);
    chk("ebreak_valid", 64'(wb_valid_o), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("halt_ready", 64'(mem_ready_o), 0);
    chk("halt_retire", retire_cnt_o, 1);
    chk("halt_pc", pc_wb_o, 64'h80000300);
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
